// File: rtl/mul_seq.sv
// Sequential radix-2 shift-add multiplier producing a 2*WIDTH-bit product
// for the Hi/Lo register file. Signed operations multiply the magnitudes and
// restore the sign in a final fix-up cycle. madd/msub differ from mult only
// in the Enable write code; no accumulation happens here.
module mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 Start,
  input  logic [1:0]           Op,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 Busy,
  output logic                 Done,
  output logic [2*WIDTH-1:0]   Product,
  output logic [3:0]           Enable
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [1:0] OP_MULTU = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     a_mag_q, a_mag_d;
  logic [WIDTH-1:0]     b_mag_q, b_mag_d;
  logic [1:0]           op_q, op_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [3:0]           enable_q, enable_d;
  logic [WIDTH:0]       sum_c;

  // Unsigned magnitude; -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits.
  function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v,
                                             input logic is_signed);
    logic [WIDTH-1:0] r;
    r = v;
    if (is_signed && v[WIDTH-1]) r = ~v + WIDTH'(1);
    return r;
  endfunction

  // Two's-complement negate of the full-width magnitude; zero stays zero.
  function automatic logic [2*WIDTH-1:0] f_apply_sign(input logic [2*WIDTH-1:0] m,
                                                      input logic neg);
    logic [2*WIDTH-1:0] r;
    r = m;
    if (neg) r = ~m + (2*WIDTH)'(1);
    return r;
  endfunction

  // Hi/Lo write code for the completed operation.
  function automatic logic [3:0] f_enable(input logic [1:0] op);
    logic [3:0] r;
    case (op)
      2'b10:   r = 4'd4;
      2'b11:   r = 4'd5;
      default: r = 4'd3;
    endcase
    return r;
  endfunction

  // Next-state and datapath: one multiplier bit per CALC cycle, LSB first.
  // The partial product is added into the upper half and the whole
  // accumulator shifts right, so after WIDTH steps it holds the magnitude.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_mag_d   = a_mag_q;
    b_mag_d   = b_mag_q;
    op_d      = op_q;
    neg_d     = neg_q;
    acc_d     = acc_q;
    product_d = product_q;
    busy_d    = busy_q;
    done_d    = done_q;
    enable_d  = enable_q;
    sum_c     = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
              + {1'b0, (b_mag_q[cnt_q] ? a_mag_q : {WIDTH{1'b0}})};
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_CALC;
          a_mag_d = f_mag(A, Op != OP_MULTU);
          b_mag_d = f_mag(B, Op != OP_MULTU);
          op_d    = Op;
          neg_d   = (Op != OP_MULTU) && (A[WIDTH-1] ^ B[WIDTH-1]);
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_CALC: begin
        acc_d = {sum_c, acc_q[WIDTH-1:1]};
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          state_d = S_FIX;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FIX: begin
        state_d   = S_DONE;
        product_d = f_apply_sign(acc_q, neg_q);
        busy_d    = 1'b0;
        done_d    = 1'b1;
        enable_d  = f_enable(op_q);
      end
      default: begin
        state_d  = S_IDLE;
        done_d   = 1'b0;
        enable_d = 4'd0;
      end
    endcase
  end

  // State, operand and output registers; reset aborts any operation.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      a_mag_q   <= '0;
      b_mag_q   <= '0;
      op_q      <= 2'b00;
      neg_q     <= 1'b0;
      acc_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      enable_q  <= 4'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_mag_q   <= a_mag_d;
      b_mag_q   <= b_mag_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      enable_q  <= enable_d;
    end
  end

  assign Busy    = busy_q;
  assign Done    = done_q;
  assign Product = product_q;
  assign Enable  = enable_q;

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: a transaction-level reference model
// (accept time, expected product, expected write code) is compared against
// the outputs every cycle, plus directed literal checks on known products.
module tb_mul_seq;

  localparam int W = 32;

  logic          Clk;
  logic          Rst_n;
  logic          Start;
  logic [1:0]    Op;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          Busy;
  logic          Done;
  logic [2*W-1:0] Product;
  logic [3:0]    Enable;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // reference model state
  bit             m_active = 0;
  int             m_k = 0;
  logic [2*W-1:0] m_prod = '0;
  logic [2*W-1:0] m_hold = '0;
  logic [3:0]     m_code = 4'd0;

  mul_seq #(.WIDTH(W)) dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .Start   (Start),
    .Op      (Op),
    .A       (A),
    .B       (B),
    .Busy    (Busy),
    .Done    (Done),
    .Product (Product),
    .Enable  (Enable)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc++;

  function automatic logic [2*W-1:0] ref_prod(input logic [1:0] op,
                                              input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    logic signed [2*W-1:0] sa, sb;
    logic [2*W-1:0] ua, ub;
    ua = {{W{1'b0}}, a};
    ub = {{W{1'b0}}, b};
    sa = {{W{a[W-1]}}, a};
    sb = {{W{b[W-1]}}, b};
    if (op == 2'b01) return ua * ub;
    return sa * sb;
  endfunction

  function automatic logic [3:0] ref_code(input logic [1:0] op);
    if (op == 2'b10) return 4'd4;
    if (op == 2'b11) return 4'd5;
    return 4'd3;
  endfunction

  task automatic chk(input string name, input logic [2*W-1:0] act,
                     input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Model: an accepted op is busy for W+1 cycles, shows Done in the next,
  // then needs one idle cycle before another Start can be taken.
  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      m_active = 0;
      m_k      = 0;
      m_hold   = '0;
    end else if (m_active) begin
      m_k++;
      if (m_k == W + 2) m_hold = m_prod;
      if (m_k == W + 3) m_active = 0;
    end else if (Start) begin
      m_active = 1;
      m_k      = 1;
      m_prod   = ref_prod(Op, A, B);
      m_code   = ref_code(Op);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge Clk) begin
    logic e_busy, e_done;
    e_busy = m_active && (m_k <= W + 1);
    e_done = m_active && (m_k == W + 2);
    chk("busy", 64'(Busy), 64'(e_busy));
    chk("done", 64'(Done), 64'(e_done));
    chk("enable", 64'(Enable), e_done ? 64'(m_code) : 64'd0);
    chk("product", Product, m_hold);
  end

  // Issue one op from idle, wait for Done, check latency and results.
  task automatic run_op(input string nm, input logic [1:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp_p, input logic [3:0] exp_en);
    int n;
    bit seen;
    @(posedge Clk); #1;
    Op = op; A = a; B = b; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    seen = 0;
    n = 0;
    while (!seen && n < 80) begin
      @(negedge Clk);
      n++;
      if (Done) seen = 1;
    end
    chk({nm, " latency"}, seen ? 64'(n) : 64'd0, 64'(W + 2));
    chk({nm, " product"}, Product, exp_p);
    chk({nm, " enable"}, 64'(Enable), 64'(exp_en));
  endtask

  task automatic wait_done(input string nm);
    int n;
    bit seen;
    seen = 0;
    n = 0;
    while (!seen && n < 80) begin
      @(negedge Clk);
      n++;
      if (Done) seen = 1;
    end
    chk({nm, " done seen"}, 64'(seen), 64'd1);
  endtask

  initial begin
    int d[3];
    int nd;
    int sel;
    logic [1:0] rop;
    logic [W-1:0] ra, rb;

    Rst_n = 1'b0; Start = 1'b0; Op = 2'b00; A = '0; B = '0;
    #1;
    chk("reset busy", 64'(Busy), 64'd0);
    chk("reset done", 64'(Done), 64'd0);
    chk("reset enable", 64'(Enable), 64'd0);
    chk("reset product", Product, 64'd0);
    repeat (2) @(negedge Clk);
    #2 Rst_n = 1'b1;

    run_op("mult 7x-3", 2'b00, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 4'd3);
    run_op("multu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 4'd3);
    run_op("mult -1x-1", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 4'd3);
    run_op("mult min^2", 2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 4'd3);
    run_op("mult minx1", 2'b00, 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000, 4'd3);
    run_op("madd 2x5", 2'b10, 32'd2, 32'd5, 64'd10, 4'd4);
    run_op("msub 2x5", 2'b11, 32'd2, 32'd5, 64'd10, 4'd5);
    run_op("mult 0x-5", 2'b00, 32'd0, 32'hFFFF_FFFB, 64'd0, 4'd3);

    // Start re-asserted mid-CALC and in the DONE cycle must be ignored.
    @(posedge Clk); #1;
    Op = 2'b00; A = 32'd100; B = 32'd200; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (4) @(posedge Clk);
    #1 Op = 2'b01; A = 32'd9; B = 32'd9; Start = 1'b1;
    @(posedge Clk); #1 Start = 1'b0;
    wait_done("ignore start");
    chk("ignore start product", Product, 64'd20000);
    Op = 2'b00; A = 32'd3; B = 32'd3; Start = 1'b1;
    @(posedge Clk); #1 Start = 1'b0;
    @(negedge Clk);
    chk("start in done ignored", 64'(Busy), 64'd0);
    run_op("mult 3x3", 2'b00, 32'd3, 32'd3, 64'd9, 4'd3);

    // Start held high: one result every W+3 cycles.
    @(posedge Clk); #1;
    Op = 2'b11; A = 32'hFFFF_FFFE; B = 32'd3; Start = 1'b1;
    nd = 0;
    for (int i = 0; i < 4 * (W + 3) && nd < 3; i++) begin
      @(negedge Clk);
      if (Done) begin
        d[nd] = cyc;
        nd++;
      end
    end
    Start = 1'b0;
    chk("b2b count", 64'(nd), 64'd3);
    if (nd == 3) begin
      chk("b2b spacing1", 64'(d[1] - d[0]), 64'(W + 3));
      chk("b2b spacing2", 64'(d[2] - d[1]), 64'(W + 3));
    end

    // Asynchronous reset in the middle of CALC.
    @(posedge Clk); #1;
    Op = 2'b00; A = 32'h1234; B = 32'h5678; Start = 1'b1;
    @(posedge Clk); #1 Start = 1'b0;
    repeat (10) @(negedge Clk);
    #2 Rst_n = 1'b0;
    #1;
    chk("abort busy", 64'(Busy), 64'd0);
    chk("abort done", 64'(Done), 64'd0);
    chk("abort enable", 64'(Enable), 64'd0);
    chk("abort product", Product, 64'd0);
    @(negedge Clk);
    #2 Rst_n = 1'b1;
    repeat (W + 4) @(negedge Clk);
    run_op("mult 0x12345678", 2'b00, 32'd0, 32'h1234_5678, 64'd0, 4'd3);

    // Randomized ops with corner-biased operands.
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 3);
      ra = (sel == 0) ? $urandom() : (sel == 1) ? 32'h8000_0000 :
           (sel == 2) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 15));
      sel = $urandom_range(0, 3);
      rb = (sel == 0) ? $urandom() : (sel == 1) ? 32'h8000_0000 :
           (sel == 2) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 15));
      run_op("random", rop, ra, rb, ref_prod(rop, ra, rb), ref_code(rop));
      repeat ($urandom_range(0, 3)) @(posedge Clk);
    end

    repeat (3) @(negedge Clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
